// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-requester arbiter.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_enc4.sv
// 4:2 priority encoder, highest set bit wins, with an optional rotation of the
// search start so the same block serves fixed and round-robin selection.
module prio_enc4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  input  logic [ID_W-1:0]  rot,
  output logic [ID_W-1:0]  idx,
  output logic             valid
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rv;
  logic [ID_W-1:0]    local_idx;

  always_comb begin
    // rv[j] = vec[(j + rot) mod 4]; rv[3] is therefore requester rot-1.
    dbl = {vec, vec} >> rot;
    rv  = dbl[N_REQ-1:0];

    local_idx = 2'd0;
    if (rv[3])      local_idx = 2'd3;
    else if (rv[2]) local_idx = 2'd2;
    else if (rv[1]) local_idx = 2'd1;
    else            local_idx = 2'd0;

    idx   = local_idx + rot;
    valid = |vec;
  end

endmodule

// File: rtl/req_arbiter4.sv
// Registered 4-requester arbiter with hold limit and one idle cycle between
// tenures. Define ARB_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module req_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout,
  output logic [1:0]       state_dbg
);

  // Handshake: req[i] is a level request; requester i owns the resource on
  // every cycle gnt[i] is high and releases it by dropping req[i].

  arb_state_e       state, state_n;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
  logic [ID_W-1:0]  last_id, last_id_n;
  logic [N_REQ-1:0] mask, mask_n;
  logic [N_REQ-1:0] gnt_n;
  logic [ID_W-1:0]  gnt_id_n;
  logic             timeout_n;

  logic [N_REQ-1:0] eligible;
  logic [ID_W-1:0]  rot;
  logic [ID_W-1:0]  win_id;
  logic             win_valid;

  assign eligible = req & ~mask;

`ifdef ARB_ROUND_ROBIN_EN
  assign rot = last_id;
`else
  assign rot = '0;
`endif

  prio_enc4 u_enc (
    .vec   (eligible),
    .rot   (rot),
    .idx   (win_id),
    .valid (win_valid)
  );

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    last_id_n  = last_id;
    mask_n     = mask;
    gnt_n      = gnt;
    gnt_id_n   = gnt_id;
    timeout_n  = 1'b0;

    case (state)
      IDLE, GAP: begin
        // The mask only ever covers one evaluation.
        mask_n = '0;
        if (win_valid) begin
          gnt_n      = onehot(win_id);
          gnt_id_n   = win_id;
          hold_cnt_n = CNT_W'(1);
          last_id_n  = win_id;
          state_n    = GRANT;
        end else begin
          gnt_n    = '0;
          gnt_id_n = '0;
          state_n  = IDLE;
        end
      end
      GRANT: begin
        if (!req[gnt_id]) begin
          gnt_n    = '0;
          gnt_id_n = '0;
          mask_n   = '0;
          state_n  = GAP;
        end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LIMIT) begin
          gnt_n     = '0;
          gnt_id_n  = '0;
          timeout_n = 1'b1;
          mask_n    = onehot(gnt_id);
          state_n   = GAP;
        end else if (hold_cnt != CNT_MAX) begin
          hold_cnt_n = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        gnt_n    = '0;
        gnt_id_n = '0;
        mask_n   = '0;
        state_n  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last_id  <= '0;
      mask     <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_cnt_n;
      last_id  <= last_id_n;
      mask     <= mask_n;
      gnt      <= gnt_n;
      gnt_id   <= gnt_id_n;
      timeout  <= timeout_n;
    end
  end

  assign gnt_valid = |gnt;
  assign state_dbg = state;

endmodule

// File: doc/req_arbiter4.md
Name: req_arbiter4

Overview:
- Sequential 4-requester arbiter for one shared resource (bus, port or engine).
- Built around a 4:2 priority encode: req[3] has the highest priority and req[0] the lowest.
- Registers the grant and holds it while the winner keeps requesting.
- Enforces a maximum hold time and inserts one idle cycle between grants.

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles per tenure; 0 = unlimited.
- CNT_W, 5: hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit i = requester i; level-sensitive.
- gnt  output 4  one-hot grant, registered; all zeros when idle.
- gnt_id  output 2  binary index of the granted requester; 0 when idle.
- gnt_valid  output 1  high while any grant is active (equals OR of gnt).
- timeout  output 1  one-cycle pulse when a tenure is force-ended by MAX_HOLD.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - gnt=0, gnt_id=0, gnt_valid=0, timeout=0
  - state=IDLE, hold_cnt=0, last_id=0, mask=0
- Reset mid-tenure drops the grant on the next edge, with no timeout pulse.
- States are IDLE, GRANT and GAP.
- Arbitration is evaluated in IDLE and GAP only. Eligible vector = req & ~mask.
  - If eligible != 0: winner = highest set bit. On the next edge gnt=onehot(winner), gnt_id=winner, gnt_valid=1, hold_cnt=1, last_id=winner, mask=0, state -> GRANT.
  - If eligible == 0: outputs stay 0 and state -> IDLE. mask clears (mask lasts for exactly one arbitration evaluation).
- Latency: req sampled at edge N produces gnt at edge N+1, i.e. one cycle.
- GRANT:
  - If req[gnt_id]=0: next edge clears gnt/gnt_valid/gnt_id, state -> GAP, mask=0.
  - Else if MAX_HOLD != 0 and hold_cnt == MAX_HOLD: next edge clears the grant, timeout=1 for that one cycle, mask=onehot(gnt_id), state -> GAP.
  - Else: hold the grant and set hold_cnt=hold_cnt+1, saturating at 2^CNT_W-1 when MAX_HOLD=0.
- Maximum grant length is MAX_HOLD cycles.
- Requests from other requesters during GRANT are ignored; there is no preemption, even by req[3].
- GAP: outputs are zero for exactly one cycle, then arbitration runs as in IDLE. Minimum turnaround is therefore one idle cycle between tenures.
- Masking: a requester that timed out is excluded from the arbitration in the following GAP only. If it is the sole requester, it is re-granted on the next evaluation after that.
- Requests that drop while not granted are simply lost; there is no request latching.
- Invariants:
  - gnt is one-hot or zero.
  - gnt_valid == |gnt.
  - timeout is never high together with gnt_valid.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Search order starts at (last_id-1) mod 4 and descends with wrap, so the last winner gets the lowest priority.
  - After reset last_id=0, so the first search order is 3,2,1,0, identical to fixed priority.
  - Masking and timeout behave as without the macro.
- Undefined: fixed priority 3>2>1>0; last_id is still tracked but does not affect selection.

Decomposition:
- Package arb_pkg:
  - N_REQ=4, ID_W=2
  - state encodings IDLE=2'd0, GRANT=2'd1, GAP=2'd2
- One combinational sub-module, prio_enc4:
  - Inputs: 4-bit vector. Outputs: 2-bit index and valid, highest bit wins.
  - Round-robin mode rotates the vector by last_id before encoding and un-rotates the index after.
  - Both modes instantiate it.

Test Plan:
- Reset then req=4'b0101 held: gnt=4'b0100 and gnt_id=2 one cycle later. Drop req[2]: gnt=0 for one cycle (GAP), then gnt=4'b0001, gnt_id=0.
- Simultaneous req=4'b1111 from IDLE: gnt=4'b1000. Raising other requests during GRANT leaves the grant unchanged (no preemption).
- MAX_HOLD=4, req=4'b0010 held continuously:
  - gnt high 4 cycles, then timeout=1 with gnt=0 for one cycle.
  - The GAP arbitration sees mask=4'b0010, so no grant.
  - Re-grant to 1 on the next evaluation.
- MAX_HOLD=4, req=4'b1001 held: grant 3 for 4 cycles, timeout, then grant 0 (3 masked). After 0 releases, 3 is granted again.
- rst=1 asserted during the 2nd grant cycle: the next edge gives gnt=0, gnt_valid=0, timeout=0 and state IDLE. Arbitration resumes one cycle after rst falls.
- With ARB_ROUND_ROBIN_EN, req=4'b1111 held and MAX_HOLD=1:
  - Grant order is 3,2,1,0,3, separated by GAP cycles.
  - A timeout pulse follows each 1-cycle tenure.
